// File: rtl/pe_pkg.sv
// Shared definitions for the PE MAC pipeline.
// Contents: the opcode enum (MAC, ACC, LOAD, CLR) and the default widths
// used by pe_mac_pipe, pe_mac_pipe_if and the bench.
package pe_pkg;

    typedef enum logic [1:0] {
        PE_OP_MAC  = 2'd0,
        PE_OP_ACC  = 2'd1,
        PE_OP_LOAD = 2'd2,
        PE_OP_CLR  = 2'd3
    } pe_op_e;

    localparam int unsigned PE_DATA_BITWIDTH     = 8;
    localparam int unsigned PE_PSUM_BITWIDTH     = 20;
    localparam int unsigned PE_IFMAP_SPAD_AWIDTH = 4;
    localparam int unsigned PE_WGHT_SPAD_AWIDTH  = 7;
    localparam int unsigned PE_PSUM_SPAD_AWIDTH  = 3;

endpackage

// File: rtl/pe_mac_pipe_if.sv
// Issue/result bus between the PE controller (master) and pe_mac_pipe (slave).
// Issue side: i_valid, i_op, i_ifmap_raddr, i_wght_raddr, i_psum_addr,
//             i_psum_we, i_out_en, i_psum_data
// Result side: o_psum_data, o_psum_valid, o_busy
interface pe_mac_pipe_if
    import pe_pkg::*;
#(
    parameter int unsigned DATA_BITWIDTH     = PE_DATA_BITWIDTH,
    parameter int unsigned PSUM_BITWIDTH     = PE_PSUM_BITWIDTH,
    parameter int unsigned IFMAP_SPAD_AWIDTH = PE_IFMAP_SPAD_AWIDTH,
    parameter int unsigned WGHT_SPAD_AWIDTH  = PE_WGHT_SPAD_AWIDTH,
    parameter int unsigned PSUM_SPAD_AWIDTH  = PE_PSUM_SPAD_AWIDTH
) ();

    logic                         i_valid;
    pe_op_e                       i_op;
    logic [IFMAP_SPAD_AWIDTH-1:0] i_ifmap_raddr;
    logic [WGHT_SPAD_AWIDTH-1:0]  i_wght_raddr;
    logic [PSUM_SPAD_AWIDTH-1:0]  i_psum_addr;
    logic                         i_psum_we;
    logic                         i_out_en;
    logic [PSUM_BITWIDTH-1:0]     i_psum_data;
    logic [PSUM_BITWIDTH-1:0]     o_psum_data;
    logic                         o_psum_valid;
    logic                         o_busy;

    modport master (
        output i_valid, i_op, i_ifmap_raddr, i_wght_raddr, i_psum_addr,
               i_psum_we, i_out_en, i_psum_data,
        input  o_psum_data, o_psum_valid, o_busy
    );

    modport slave (
        input  i_valid, i_op, i_ifmap_raddr, i_wght_raddr, i_psum_addr,
               i_psum_we, i_out_en, i_psum_data,
        output o_psum_data, o_psum_valid, o_busy
    );

endinterface

// File: rtl/pe_spad.sv
// Single-write-port, asynchronous-read scratchpad (no reset on contents).
// Ports: i_clk, i_we/i_waddr/i_wdata (synchronous write),
//        i_raddr -> o_rdata (combinational read; a same-cycle write to the
//        same address is seen only from the next cycle).
module pe_spad #(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned AWIDTH = 4
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [AWIDTH-1:0] i_waddr,
    input  logic [DWIDTH-1:0] i_wdata,
    input  logic [AWIDTH-1:0] i_raddr,
    output logic [DWIDTH-1:0] o_rdata
);

    localparam int unsigned DEPTH = 1 << AWIDTH;

    logic [DWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/pe_mac_pipe.sv
// PE datapath: ifmap/weight/psum scratchpads feeding a 3-stage MAC pipeline.
// Ports: i_clk, i_rst (sync, active-high), i_en (pipeline advance),
//        ifmap/weight spad write ports, bus (pe_mac_pipe_if.slave) carrying
//        the issue fields and the registered psum result / busy flag.
// Optional: define PE_PSUM_SATURATE_EN to saturate MAC/ACC results to the
//        PSUM_BITWIDTH range instead of wrapping.
module pe_mac_pipe
    import pe_pkg::*;
#(
    parameter int unsigned DATA_BITWIDTH     = PE_DATA_BITWIDTH,
    parameter int unsigned PSUM_BITWIDTH     = PE_PSUM_BITWIDTH,
    parameter int unsigned IFMAP_SPAD_AWIDTH = PE_IFMAP_SPAD_AWIDTH,
    parameter int unsigned WGHT_SPAD_AWIDTH  = PE_WGHT_SPAD_AWIDTH,
    parameter int unsigned PSUM_SPAD_AWIDTH  = PE_PSUM_SPAD_AWIDTH,
    parameter int unsigned SIGNED            = 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_en,
    input  logic                         i_ifmap_we,
    input  logic [IFMAP_SPAD_AWIDTH-1:0] i_ifmap_waddr,
    input  logic [DATA_BITWIDTH-1:0]     i_ifmap_data,
    input  logic                         i_wght_we,
    input  logic [WGHT_SPAD_AWIDTH-1:0]  i_wght_waddr,
    input  logic [DATA_BITWIDTH-1:0]     i_wght_data,
    pe_mac_pipe_if.slave                 bus
);

    localparam int unsigned PROD_W = 2 * DATA_BITWIDTH;
    localparam int unsigned P      = PSUM_BITWIDTH;

    logic [DATA_BITWIDTH-1:0] ifmap_rdata, wght_rdata;
    logic [P-1:0]             psum_rdata;
    logic                     psum_spad_we;

    // S0 registers
    logic                        s0_valid, s0_we, s0_oe;
    pe_op_e                      s0_op;
    logic [DATA_BITWIDTH-1:0]    s0_ifmap, s0_wght;
    logic [P-1:0]                s0_psum_in;
    logic [PSUM_SPAD_AWIDTH-1:0] s0_paddr;
    // S1 registers
    logic                        s1_valid, s1_we, s1_oe;
    pe_op_e                      s1_op;
    logic [PROD_W-1:0]           s1_prod;
    logic [P-1:0]                s1_psum_in;
    logic [PSUM_SPAD_AWIDTH-1:0] s1_paddr;
    // S2 / output registers
    logic                        s2_valid;

    logic [PROD_W-1:0] op_a, op_b, prod;
    logic [P-1:0]      prod_ext, addend, result;

    pe_spad #(.DWIDTH(DATA_BITWIDTH), .AWIDTH(IFMAP_SPAD_AWIDTH)) u_ifmap_spad (
        .i_clk(i_clk), .i_we(i_ifmap_we), .i_waddr(i_ifmap_waddr),
        .i_wdata(i_ifmap_data), .i_raddr(bus.i_ifmap_raddr), .o_rdata(ifmap_rdata)
    );

    pe_spad #(.DWIDTH(DATA_BITWIDTH), .AWIDTH(WGHT_SPAD_AWIDTH)) u_wght_spad (
        .i_clk(i_clk), .i_we(i_wght_we), .i_waddr(i_wght_waddr),
        .i_wdata(i_wght_data), .i_raddr(bus.i_wght_raddr), .o_rdata(wght_rdata)
    );

    // Read-modify-write of the psum entry happens entirely in the S2 cycle,
    // so a back-to-back op to the same address sees the previous result.
    assign psum_spad_we = i_en && !i_rst && s1_valid && s1_we;

    pe_spad #(.DWIDTH(P), .AWIDTH(PSUM_SPAD_AWIDTH)) u_psum_spad (
        .i_clk(i_clk), .i_we(psum_spad_we), .i_waddr(s1_paddr),
        .i_wdata(result), .i_raddr(s1_paddr), .o_rdata(psum_rdata)
    );

    // Operands are extended to the product width first so the low PROD_W
    // bits of the multiply are correct for both signed and unsigned modes.
    always_comb begin
        if (SIGNED != 0) begin
            op_a     = PROD_W'($signed(s0_ifmap));
            op_b     = PROD_W'($signed(s0_wght));
            prod_ext = P'($signed(s1_prod));
        end else begin
            op_a     = PROD_W'(s0_ifmap);
            op_b     = PROD_W'(s0_wght);
            prod_ext = P'(s1_prod);
        end
        prod = op_a * op_b;
    end

    assign addend = (s1_op == PE_OP_ACC) ? s1_psum_in : prod_ext;

`ifdef PE_PSUM_SATURATE_EN
    localparam logic [P-1:0] SAT_MAX = (SIGNED != 0) ? {1'b0, {(P-1){1'b1}}} : '1;
    localparam logic [P-1:0] SAT_MIN = (SIGNED != 0) ? {1'b1, {(P-1){1'b0}}} : '0;

    function automatic logic [P:0] ext1(input logic [P-1:0] x);
        return (SIGNED != 0) ? {x[P-1], x} : {1'b0, x};
    endfunction

    logic [P:0] sum;
    logic       ovf;

    always_comb begin
        sum = ext1(psum_rdata) + ext1(addend);
        // Signed: top two bits disagree on overflow. Unsigned: carry out.
        ovf = (SIGNED != 0) ? (sum[P] != sum[P-1]) : sum[P];
        result = '0;
        case (s1_op)
            PE_OP_MAC, PE_OP_ACC: begin
                if (!ovf)             result = sum[P-1:0];
                else if (SIGNED == 0) result = SAT_MAX;
                else                  result = sum[P] ? SAT_MIN : SAT_MAX;
            end
            PE_OP_LOAD: result = s1_psum_in;
            default:    result = '0;
        endcase
    end
`else
    // Modular wrap: the P+1-bit sum truncated to P bits equals a P-bit add.
    always_comb begin
        result = '0;
        case (s1_op)
            PE_OP_MAC, PE_OP_ACC: result = psum_rdata + addend;
            PE_OP_LOAD:           result = s1_psum_in;
            default:              result = '0;
        endcase
    end
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s0_valid         <= 1'b0;
            s0_we            <= 1'b0;
            s0_oe            <= 1'b0;
            s0_op            <= PE_OP_MAC;
            s0_ifmap         <= '0;
            s0_wght          <= '0;
            s0_psum_in       <= '0;
            s0_paddr         <= '0;
            s1_valid         <= 1'b0;
            s1_we            <= 1'b0;
            s1_oe            <= 1'b0;
            s1_op            <= PE_OP_MAC;
            s1_prod          <= '0;
            s1_psum_in       <= '0;
            s1_paddr         <= '0;
            s2_valid         <= 1'b0;
            bus.o_psum_data  <= '0;
            bus.o_psum_valid <= 1'b0;
        end else if (i_en) begin
            s0_valid   <= bus.i_valid;
            s0_we      <= bus.i_psum_we;
            s0_oe      <= bus.i_out_en;
            s0_op      <= bus.i_op;
            s0_ifmap   <= ifmap_rdata;
            s0_wght    <= wght_rdata;
            s0_psum_in <= bus.i_psum_data;
            s0_paddr   <= bus.i_psum_addr;

            s1_valid   <= s0_valid;
            s1_we      <= s0_we;
            s1_oe      <= s0_oe;
            s1_op      <= s0_op;
            s1_prod    <= prod;
            s1_psum_in <= s0_psum_in;
            s1_paddr   <= s0_paddr;

            s2_valid         <= s1_valid;
            bus.o_psum_valid <= s1_valid && s1_oe;
            if (s1_valid) begin
                bus.o_psum_data <= result;
            end
        end
    end

    assign bus.o_busy = s0_valid || s1_valid || s2_valid;

endmodule

// File: tb/tb_pe_mac_pipe.sv
// Directed bench for pe_mac_pipe: a SIGNED=1 and a SIGNED=0 instance share
// all stimulus; expected values are hand-computed constants.
module tb_pe_mac_pipe;
    import pe_pkg::*;

    localparam int unsigned D  = 8;
    localparam int unsigned P  = 20;
    localparam int unsigned IA = 4;
    localparam int unsigned WA = 7;
    localparam int unsigned PA = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, en;
    logic          ifmap_we, wght_we;
    logic [IA-1:0] ifmap_waddr;
    logic [D-1:0]  ifmap_data;
    logic [WA-1:0] wght_waddr;
    logic [D-1:0]  wght_data;

    logic          valid, psum_we, out_en;
    pe_op_e        op;
    logic [IA-1:0] ifmap_raddr;
    logic [WA-1:0] wght_raddr;
    logic [PA-1:0] psum_addr;
    logic [P-1:0]  psum_in;

    pe_mac_pipe_if #(.DATA_BITWIDTH(D), .PSUM_BITWIDTH(P), .IFMAP_SPAD_AWIDTH(IA),
                     .WGHT_SPAD_AWIDTH(WA), .PSUM_SPAD_AWIDTH(PA)) bus_s ();
    pe_mac_pipe_if #(.DATA_BITWIDTH(D), .PSUM_BITWIDTH(P), .IFMAP_SPAD_AWIDTH(IA),
                     .WGHT_SPAD_AWIDTH(WA), .PSUM_SPAD_AWIDTH(PA)) bus_u ();

    assign bus_s.i_valid = valid;        assign bus_u.i_valid = valid;
    assign bus_s.i_op = op;              assign bus_u.i_op = op;
    assign bus_s.i_ifmap_raddr = ifmap_raddr; assign bus_u.i_ifmap_raddr = ifmap_raddr;
    assign bus_s.i_wght_raddr = wght_raddr;   assign bus_u.i_wght_raddr = wght_raddr;
    assign bus_s.i_psum_addr = psum_addr;     assign bus_u.i_psum_addr = psum_addr;
    assign bus_s.i_psum_we = psum_we;    assign bus_u.i_psum_we = psum_we;
    assign bus_s.i_out_en = out_en;      assign bus_u.i_out_en = out_en;
    assign bus_s.i_psum_data = psum_in;  assign bus_u.i_psum_data = psum_in;

    pe_mac_pipe #(.DATA_BITWIDTH(D), .PSUM_BITWIDTH(P), .IFMAP_SPAD_AWIDTH(IA),
                  .WGHT_SPAD_AWIDTH(WA), .PSUM_SPAD_AWIDTH(PA), .SIGNED(1)) dut_s (
        .i_clk(clk), .i_rst(rst), .i_en(en),
        .i_ifmap_we(ifmap_we), .i_ifmap_waddr(ifmap_waddr), .i_ifmap_data(ifmap_data),
        .i_wght_we(wght_we), .i_wght_waddr(wght_waddr), .i_wght_data(wght_data),
        .bus(bus_s)
    );

    pe_mac_pipe #(.DATA_BITWIDTH(D), .PSUM_BITWIDTH(P), .IFMAP_SPAD_AWIDTH(IA),
                  .WGHT_SPAD_AWIDTH(WA), .PSUM_SPAD_AWIDTH(PA), .SIGNED(0)) dut_u (
        .i_clk(clk), .i_rst(rst), .i_en(en),
        .i_ifmap_we(ifmap_we), .i_ifmap_waddr(ifmap_waddr), .i_ifmap_data(ifmap_data),
        .i_wght_we(wght_we), .i_wght_waddr(wght_waddr), .i_wght_data(wght_data),
        .bus(bus_u)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_spads(input logic [IA-1:0] ia, input logic [D-1:0] id,
                            input logic [WA-1:0] wa, input logic [D-1:0] wd);
        ifmap_we = 1'b1; ifmap_waddr = ia; ifmap_data = id;
        wght_we  = 1'b1; wght_waddr  = wa; wght_data  = wd;
        tick();
        ifmap_we = 1'b0; wght_we = 1'b0;
    endtask

    task automatic issue(input pe_op_e o, input logic [IA-1:0] ia, input logic [WA-1:0] wa,
                         input logic [PA-1:0] pa, input logic we, input logic oe,
                         input logic [P-1:0] pin);
        op = o; ifmap_raddr = ia; wght_raddr = wa; psum_addr = pa;
        psum_we = we; out_en = oe; psum_in = pin; valid = 1'b1;
        tick();
        valid = 1'b0;
    endtask

    // Issue one op and stop in the cycle its result is on the output.
    task automatic run_op(input pe_op_e o, input logic [IA-1:0] ia, input logic [WA-1:0] wa,
                          input logic [PA-1:0] pa, input logic we, input logic oe,
                          input logic [P-1:0] pin);
        issue(o, ia, wa, pa, we, oe, pin);
        tick();
        tick();
    endtask

    logic [31:0] exp_wrap;

    initial begin
        rst = 1'b1; en = 1'b1;
        ifmap_we = 1'b0; ifmap_waddr = '0; ifmap_data = '0;
        wght_we = 1'b0; wght_waddr = '0; wght_data = '0;
        valid = 1'b0; op = PE_OP_MAC; ifmap_raddr = '0; wght_raddr = '0;
        psum_addr = '0; psum_we = 1'b0; out_en = 1'b0; psum_in = '0;
        tick();
        tick();
        check("rst_data",  32'(bus_s.o_psum_data), 32'h0);
        check("rst_valid", 32'(bus_s.o_psum_valid), 32'h0);
        check("rst_busy",  32'(bus_s.o_busy), 32'h0);
        rst = 1'b0;

        // Basic MAC: 3*5 onto a cleared entry
        wr_spads(4'd0, 8'd3, 7'd0, 8'd5);
        run_op(PE_OP_CLR, 4'd0, 7'd0, 3'd1, 1'b1, 1'b1, 20'd0);
        check("clr_valid", 32'(bus_s.o_psum_valid), 32'h1);
        check("clr_data",  32'(bus_s.o_psum_data), 32'h0);
        run_op(PE_OP_MAC, 4'd0, 7'd0, 3'd1, 1'b1, 1'b1, 20'd0);
        check("mac_valid", 32'(bus_s.o_psum_valid), 32'h1);
        check("mac_data_s", 32'(bus_s.o_psum_data), 32'd15);
        check("mac_data_u", 32'(bus_u.o_psum_data), 32'd15);
        run_op(PE_OP_ACC, 4'd0, 7'd0, 3'd1, 1'b0, 1'b1, 20'd0);
        check("mac_spad", 32'(bus_s.o_psum_data), 32'd15);

        // Signed vs unsigned product of 0xFC * 7
        wr_spads(4'd1, 8'hFC, 7'd1, 8'd7);
        run_op(PE_OP_CLR, 4'd0, 7'd0, 3'd3, 1'b1, 1'b0, 20'd0);
        check("oe0_valid", 32'(bus_s.o_psum_valid), 32'h0);
        run_op(PE_OP_MAC, 4'd1, 7'd1, 3'd3, 1'b1, 1'b1, 20'd0);
        check("neg_s", 32'(bus_s.o_psum_data), 32'hFFFE4);
        check("neg_u", 32'(bus_u.o_psum_data), 32'h006E4);

        // Four back-to-back MACs of 2*5 to the same entry
        wr_spads(4'd2, 8'd2, 7'd2, 8'd5);
        run_op(PE_OP_CLR, 4'd0, 7'd0, 3'd2, 1'b1, 1'b0, 20'd0);
        for (int k = 0; k < 6; k++) begin
            if (k < 4) begin
                op = PE_OP_MAC; ifmap_raddr = 4'd2; wght_raddr = 7'd2; psum_addr = 3'd2;
                psum_we = 1'b1; out_en = 1'b1; psum_in = '0; valid = 1'b1;
            end else begin
                valid = 1'b0;
            end
            tick();
            if (k >= 2) begin
                check($sformatf("b2b_valid%0d", k - 2), 32'(bus_s.o_psum_valid), 32'h1);
                check($sformatf("b2b_data%0d", k - 2), 32'(bus_s.o_psum_data), 32'(10 * (k - 1)));
            end
        end
        valid = 1'b0;
        tick();
        check("b2b_drain", 32'(bus_s.o_psum_valid), 32'h0);

        // LOAD / ACC / LOAD
        run_op(PE_OP_LOAD, 4'd0, 7'd0, 3'd4, 1'b1, 1'b1, 20'd23);
        check("load23", 32'(bus_s.o_psum_data), 32'd23);
        run_op(PE_OP_ACC, 4'd0, 7'd0, 3'd4, 1'b1, 1'b1, 20'd100);
        check("acc123", 32'(bus_s.o_psum_data), 32'd123);
        run_op(PE_OP_LOAD, 4'd0, 7'd0, 3'd4, 1'b0, 1'b1, 20'd77);
        check("load77", 32'(bus_s.o_psum_data), 32'd77);

        // Two-cycle stall after issue; an issue during the stall is ignored
        run_op(PE_OP_CLR, 4'd0, 7'd0, 3'd5, 1'b1, 1'b1, 20'd0);
        issue(PE_OP_MAC, 4'd0, 7'd0, 3'd5, 1'b1, 1'b1, 20'd0);
        en = 1'b0;
        op = PE_OP_LOAD; psum_in = 20'd999; valid = 1'b1;
        tick();
        check("stall_valid0", 32'(bus_s.o_psum_valid), 32'h0);
        check("stall_busy",   32'(bus_s.o_busy), 32'h1);
        tick();
        check("stall_valid1", 32'(bus_s.o_psum_valid), 32'h0);
        check("stall_hold",   32'(bus_s.o_psum_data), 32'h0);
        valid = 1'b0;
        en = 1'b1;
        tick();
        check("stall_early", 32'(bus_s.o_psum_valid), 32'h0);
        tick();
        check("stall_out_valid", 32'(bus_s.o_psum_valid), 32'h1);
        check("stall_out_data",  32'(bus_s.o_psum_data), 32'd15);
        tick();
        check("stall_no_extra", 32'(bus_s.o_psum_valid), 32'h0);

        // Reset while a MAC to entry 1 is one cycle from writing back
        issue(PE_OP_MAC, 4'd0, 7'd0, 3'd1, 1'b1, 1'b1, 20'd0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_valid", 32'(bus_s.o_psum_valid), 32'h0);
        check("midrst_busy",  32'(bus_s.o_busy), 32'h0);
        check("midrst_data",  32'(bus_s.o_psum_data), 32'h0);
        tick();
        check("midrst_after", 32'(bus_s.o_psum_valid), 32'h0);
        run_op(PE_OP_ACC, 4'd0, 7'd0, 3'd1, 1'b0, 1'b1, 20'd0);
        check("midrst_spad", 32'(bus_s.o_psum_data), 32'd15);

        // All-ones entry plus product 1
`ifdef PE_PSUM_SATURATE_EN
        exp_wrap = 32'hFFFFF;
`else
        exp_wrap = 32'h0;
`endif
        wr_spads(4'd3, 8'd1, 7'd3, 8'd1);
        run_op(PE_OP_LOAD, 4'd0, 7'd0, 3'd6, 1'b1, 1'b0, 20'hFFFFF);
        run_op(PE_OP_MAC, 4'd3, 7'd3, 3'd6, 1'b1, 1'b1, 20'd0);
        check("wrap_u", 32'(bus_u.o_psum_data), exp_wrap);
        check("wrap_s", 32'(bus_s.o_psum_data), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
